// File: rtl/writeback_buffer.sv
// Write-back buffer between the dcache pmem port and the arbiter dcache port.
// Queues dirty evictions so read misses reach memory first, drains them in
//   the background and serves reads that hit a buffered line.
// Ports:
//   clk, reset_n                       clock, synchronous active-low reset
//   dc_address/read/write/wdata        dcache pmem request (held until dc_resp)
//   dc_rdata, dc_resp                  line returned to dcache, 1-cycle completion
//   mem_address/read/write/wdata       request to arbiter dcache port
//   mem_rdata, mem_resp                arbiter response
//   empty                              no buffered lines and no write in flight
module writeback_buffer #(
   parameter int DEPTH    = 2,
   parameter int ADDR_W   = 32,
   parameter int LINE_W   = 256,
   parameter int OFFSET_W = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] dc_address,
   input  logic              dc_read,
   input  logic              dc_write,
   input  logic [LINE_W-1:0] dc_wdata,
   output logic [LINE_W-1:0] dc_rdata,
   output logic              dc_resp,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp,
   output logic              empty
);

   localparam int TAG_W = ADDR_W - OFFSET_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      RD_MEM,
      WR_MEM,
      RESP
   } state_t;

   state_t state;

   logic [DEPTH-1:0]  valid;
   logic [TAG_W-1:0]  tags  [DEPTH];
   logic [LINE_W-1:0] lines [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;

   logic [TAG_W-1:0]  req_tag;
   logic [PTR_W-1:0]  scan_idx;
   logic              hit;
   logic [PTR_W-1:0]  hit_idx;
   logic              full;

   assign req_tag = dc_address[ADDR_W-1:OFFSET_W];
   assign full    = (count == CNT_W'(DEPTH));

   // Scan oldest to youngest; the last match wins so the youngest copy
   // of a line is the one returned or overwritten.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      scan_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = head + PTR_W'(i);
         if (CNT_W'(i) < count && valid[scan_idx] &&
             tags[scan_idx] == req_tag) begin
            hit     = 1'b1;
            hit_idx = scan_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         valid       <= '0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         dc_rdata    <= '0;
         dc_resp     <= 1'b0;
         mem_address <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_wdata   <= '0;
         empty       <= 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            tags[i]  <= '0;
            lines[i] <= '0;
         end
      end else begin
         dc_resp <= 1'b0;
         unique case (state)
            IDLE: begin
               if (dc_read && hit) begin
                  dc_rdata <= lines[hit_idx];
                  dc_resp  <= 1'b1;
                  state    <= RESP;
               end else if (dc_read) begin
                  mem_address <= dc_address;
                  mem_read    <= 1'b1;
                  state       <= RD_MEM;
               end else if (dc_write && hit) begin
                  // Nothing is in flight while IDLE, so any match may coalesce.
                  lines[hit_idx] <= dc_wdata;
                  dc_resp        <= 1'b1;
                  state          <= RESP;
               end else if (dc_write && !full) begin
                  tags[tail]  <= req_tag;
                  lines[tail] <= dc_wdata;
                  valid[tail] <= 1'b1;
                  tail        <= tail + 1'b1;
                  count       <= count + 1'b1;
                  empty       <= 1'b0;
                  dc_resp     <= 1'b1;
                  state       <= RESP;
               end else if (count != '0) begin
                  // Also taken for a write stalled on a full buffer.
                  mem_address <= {tags[head], {OFFSET_W{1'b0}}};
                  mem_wdata   <= lines[head];
                  mem_write   <= 1'b1;
                  empty       <= 1'b0;
                  state       <= WR_MEM;
               end
            end
            RD_MEM: begin
               if (mem_resp) begin
                  dc_rdata <= mem_rdata;
                  mem_read <= 1'b0;
                  dc_resp  <= 1'b1;
                  state    <= RESP;
               end
            end
            WR_MEM: begin
               if (mem_resp) begin
                  valid[head] <= 1'b0;
                  head        <= head + 1'b1;
                  count       <= count - 1'b1;
                  mem_write   <= 1'b0;
                  empty       <= (count == CNT_W'(1));
                  state       <= IDLE;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_writeback_buffer.sv
// Scoreboard bench for writeback_buffer: directed dcache traffic against a
//   simple memory responder; expected memory ops and dcache responses are queued.
module tb_writeback_buffer;

   localparam int AW = 32;
   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] dc_address;
   logic          dc_read;
   logic          dc_write;
   logic [LW-1:0] dc_wdata;
   logic [LW-1:0] dc_rdata;
   logic          dc_resp;
   logic [AW-1:0] mem_address;
   logic          mem_read;
   logic          mem_write;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata;
   logic          mem_resp;
   logic          empty;

   writeback_buffer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .dc_address  (dc_address),
      .dc_read     (dc_read),
      .dc_write    (dc_write),
      .dc_wdata    (dc_wdata),
      .dc_rdata    (dc_rdata),
      .dc_resp     (dc_resp),
      .mem_address (mem_address),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_resp    (mem_resp),
      .empty       (empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            w;
      logic [AW-1:0] a;
      logic [LW-1:0] d;
   } mem_op_t;

   typedef struct {
      bit            chk;
      logic [LW-1:0] d;
   } resp_t;

   mem_op_t exp_mem[$];
   resp_t   exp_resp[$];

   int errors = 0;
   int checks = 0;
   int mem_lat = 2;

   function automatic logic [LW-1:0] mk(input logic [31:0] s);
      return {8{s}};
   endfunction

   function automatic logic [LW-1:0] rd_pat(input logic [AW-1:0] a);
      return {8{a ^ 32'h5A5A_0000}};
   endfunction

   task automatic chk(input string nm, input logic [LW-1:0] act,
                      input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Memory responder: answers each request after mem_lat cycles.
   initial begin
      mem_resp  = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if ((mem_read === 1'b1 || mem_write === 1'b1) && !mem_resp) begin
            repeat (mem_lat) @(negedge clk);
            mem_rdata = rd_pat(mem_address);
            mem_resp  = 1'b1;
            @(negedge clk);
            mem_resp  = 1'b0;
         end
      end
   end

   // Monitor: checks every new memory op and every dcache response.
   initial begin
      bit busy_q = 1'b0;
      bit busy;
      mem_op_t op;
      resp_t   r;
      forever begin
         @(negedge clk);
         if (dc_read === 1'b1 && dc_write === 1'b1) begin
            errors++;
            $display("FAIL dc_rw_both: read and write both high");
         end
         if (mem_read === 1'b1 && mem_write === 1'b1) begin
            errors++;
            $display("FAIL mem_rw_both: mem_read and mem_write both high");
         end
         busy = (mem_read === 1'b1) || (mem_write === 1'b1);
         if (busy && !busy_q) begin
            if (exp_mem.size() == 0) begin
               errors++;
               $display("FAIL mem_unexp: op w=%0b addr %0h", mem_write, mem_address);
            end else begin
               op = exp_mem.pop_front();
               chk("mem_kind", LW'(mem_write), LW'(op.w));
               chk("mem_addr", LW'(mem_address), LW'(op.a));
               if (op.w) chk("mem_wdata", mem_wdata, op.d);
            end
         end
         busy_q = busy;
         if (dc_resp === 1'b1) begin
            if (exp_resp.size() == 0) begin
               errors++;
               $display("FAIL dc_resp_unexp: extra dc_resp");
            end else begin
               r = exp_resp.pop_front();
               if (r.chk) chk("dc_rdata", dc_rdata, r.d);
            end
         end
      end
   end

   task automatic exp_w(input logic [AW-1:0] a, input logic [LW-1:0] d);
      exp_mem.push_back('{1'b1, a, d});
   endtask

   // Tasks start just after a rising edge and return just after one.
   task automatic wait_resp(input string nm, input int exp_lat);
      int lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (dc_resp !== 1'b1 && lat < 300);
      if (dc_resp !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: no dc_resp after %0d cycles", nm, lat);
      end else if (exp_lat != 0) begin
         chk({nm, "_lat"}, LW'(lat), LW'(exp_lat));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] d,
                           input int exp_lat);
      exp_resp.push_back('{1'b0, '0});
      dc_address = a;
      dc_wdata   = d;
      dc_write   = 1'b1;
      wait_resp("wr", exp_lat);
      dc_write   = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] d,
                          input int exp_lat);
      exp_resp.push_back('{1'b1, d});
      dc_address = a;
      dc_read    = 1'b1;
      wait_resp("rd", exp_lat);
      dc_read    = 1'b0;
   endtask

   task automatic wait_empty(input string nm);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (empty !== 1'b1 && t < 300);
      chk(nm, LW'(empty), LW'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_mem_busy();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (mem_write !== 1'b1 && t < 300);
      chk("mem_busy", LW'(mem_write), LW'(1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int t;
      reset_n    = 1'b0;
      dc_address = '0;
      dc_read    = 1'b0;
      dc_write   = 1'b0;
      dc_wdata   = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_dc_resp", LW'(dc_resp), '0);
      chk("rst_dc_rdata", dc_rdata, '0);
      chk("rst_mem_read", LW'(mem_read), '0);
      chk("rst_mem_write", LW'(mem_write), '0);
      chk("rst_mem_addr", LW'(mem_address), '0);
      chk("rst_mem_wdata", mem_wdata, '0);
      chk("rst_empty", LW'(empty), LW'(1));
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Eviction then miss: read reaches memory before the write drains
      exp_mem.push_back('{1'b0, 32'h2000, '0});
      exp_w(32'h1000, mk(32'hAAAA_0001));
      do_write(32'h1000, mk(32'hAAAA_0001), 2);
      do_read(32'h2000, rd_pat(32'h2000), 0);
      wait_empty("evict_empty");

      // Buffer hit: no memory read
      exp_w(32'h3000, mk(32'hBBBB_0002));
      do_write(32'h3000, mk(32'hBBBB_0002), 2);
      do_read(32'h3000, mk(32'hBBBB_0002), 2);
      wait_empty("hit_empty");

      // Coalesce into 0x5000 while 0x4000 drains
      mem_lat = 4;
      exp_w(32'h4000, mk(32'hCCCC_0003));
      exp_w(32'h5000, mk(32'hEEEE_0005));
      do_write(32'h4000, mk(32'hCCCC_0003), 2);
      do_write(32'h5000, mk(32'hDDDD_0004), 2);
      wait_mem_busy();
      do_write(32'h5000, mk(32'hEEEE_0005), 0);
      wait_empty("coal_empty");

      // Full stall: third write waits for the head to drain
      mem_lat = 3;
      exp_w(32'h100, mk(32'h0000_0100));
      exp_w(32'h200, mk(32'h0000_0200));
      exp_w(32'h300, mk(32'h0000_0300));
      do_write(32'h100, mk(32'h0000_0100), 2);
      do_write(32'h200, mk(32'h0000_0200), 2);
      do_write(32'h300, mk(32'h0000_0300), 3 + 4);
      wait_empty("full_empty");

      // Background drain in FIFO order; empty right after the last response
      mem_lat = 2;
      exp_w(32'h600, mk(32'h6666_0006));
      exp_w(32'h700, mk(32'h7777_0007));
      do_write(32'h600, mk(32'h6666_0006), 2);
      do_write(32'h700, mk(32'h7777_0007), 2);
      n = 0;
      t = 0;
      while (n < 2 && t < 300) begin
         @(posedge clk);
         t++;
         if (mem_resp) begin
            n++;
            @(negedge clk);
            chk(n == 2 ? "drain_empty_end" : "drain_empty_mid",
                LW'(empty), LW'(n == 2));
         end
      end
      if (n < 2) begin
         errors++;
         $display("FAIL drain_timeout: saw %0d mem_resp want 2", n);
      end
      @(posedge clk);
      #1;

      // Reset in the middle of a write drain
      mem_lat = 15;
      exp_w(32'h800, mk(32'h8888_0008));
      do_write(32'h800, mk(32'h8888_0008), 2);
      wait_mem_busy();
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_mem_write", LW'(mem_write), '0);
      chk("rst_mid_empty", LW'(empty), LW'(1));
      chk("rst_mid_mem_addr", LW'(mem_address), '0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (25) @(posedge clk);
      @(negedge clk);
      chk("rst_mid_idle_empty", LW'(empty), LW'(1));
      chk("end_mem_queue", LW'(exp_mem.size()), '0);
      chk("end_resp_queue", LW'(exp_resp.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
